inversion_index_gen: RTL

Sequential pseudo-random index-pair source feeding the inversion mutation operator of the genetic brew-run engine. Holds a 16-bit Galois LFSR and draws candidate bit positions by rejection sampling until it has two distinct in-range indices within a span limit. It then presents them as an ordered pair (`idx_lo` < `idx_hi`) over a valid/ready handshake. The inversion stage consumes each pair and reverses chromosome bits `[idx_hi:idx_lo]`.

---
 rtl/inversion_index_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/inversion_index_gen.sv
// Pseudo-random ordered index-pair source for the inversion mutation stage.
// A 16-bit Galois LFSR feeds rejection sampling of two distinct in-range bit positions.
module inversion_index_gen #(
  parameter int unsigned GENOME_BITS = 150,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned MAX_SPAN    = 149
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prg_seed,
  input  logic             seed_load,
  input  logic             idx_ready,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx_lo,
  output logic [IDX_W-1:0] idx_hi,
  output logic [15:0]      rej_count
);

  localparam logic [15:0]    LFSR_RST = 16'hACE1;
  localparam logic [15:0]    TAPS     = 16'hB400;
  // One extra bit so GENOME_BITS == 2^IDX_W still compares correctly.
  localparam logic [IDX_W:0] GB_LIM   = (IDX_W+1)'(GENOME_BITS);
  localparam logic [IDX_W:0] SPAN_LIM = (IDX_W+1)'(MAX_SPAN);

  typedef enum logic [1:0] {DRAW0, DRAW1, ORDER, VALID} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] c0_q, c0_d, c1_q, c1_d;
  logic [IDX_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             valid_q, valid_d;
  logic [15:0]      rej_q, rej_d;

  logic [IDX_W-1:0] cand, ord_lo, ord_hi, span;
  logic [15:0]      lfsr_step;
  logic             in_range, pair_bad, rej_inc;

  always_comb begin
    cand      = lfsr_q[IDX_W-1:0];
    in_range  = {1'b0, cand} < GB_LIM;
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    ord_lo    = (c0_q < c1_q) ? c0_q : c1_q;
    ord_hi    = (c0_q < c1_q) ? c1_q : c0_q;
    span      = ord_hi - ord_lo;
    pair_bad  = (c0_q == c1_q) || ({1'b0, span} > SPAN_LIM);
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    rej_inc = 1'b0;
    case (state_q)
      DRAW0: begin
        lfsr_d = lfsr_step;
        if (in_range) begin
          c0_d    = cand;
          state_d = DRAW1;
        end else begin
          rej_inc = 1'b1;
        end
      end
      DRAW1: begin
        lfsr_d = lfsr_step;
        if (in_range) begin
          c1_d    = cand;
          state_d = ORDER;
        end else begin
          rej_inc = 1'b1;
        end
      end
      ORDER: begin
        if (pair_bad) begin
          rej_inc = 1'b1;
          state_d = DRAW0;
        end else begin
          lo_d    = ord_lo;
          hi_d    = ord_hi;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (valid_q && idx_ready) begin
          valid_d = 1'b0;
          state_d = DRAW0;
        end
      end
      default: state_d = DRAW0;
    endcase

    rej_d = (rej_inc && rej_q != 16'hFFFF) ? rej_q + 16'd1 : rej_q;

    // Reseed discards any pair in flight but keeps the last presented bounds and the count.
    if (seed_load) begin
      lfsr_d  = (prg_seed == 16'h0000) ? LFSR_RST : prg_seed;
      state_d = DRAW0;
      valid_d = 1'b0;
      c0_d    = c0_q;
      c1_d    = c1_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      rej_d   = rej_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRAW0;
      lfsr_q  <= LFSR_RST;
      c0_q    <= '0;
      c1_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
      rej_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      rej_q   <= rej_d;
    end
  end

  assign idx_valid = valid_q;
  assign idx_lo    = lo_q;
  assign idx_hi    = hi_q;
  assign rej_count = rej_q;

endmodule
